// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: receiver/transmitter state encoding and 16x oversampling tick positions.
package rs232_pkg;

    typedef enum logic [2:0] {
        stIdle  = 3'd0,
        stStart = 3'd1,
        stData  = 3'd2,
        stStop  = 3'd3,
        stWait  = 3'd4
    } rxState_t;

    localparam int OVERSAMPLE    = 16;
    localparam int SAMPLE_FIRST  = 7;
    localparam int SAMPLE_DECIDE = 9;
    localparam int TICK_LAST     = 15;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rs232_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module rs232_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock16x,
    input  logic Reset,
    input  logic Din,
    output logic Dout
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the raw line through the synchronizer chain
    always_ff @(posedge Clock16x or posedge Reset) begin
        if (Reset) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], Din};
        end
    end

    assign Dout = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/rs232_rxd.sv
// RS232 receiver: 16x oversampled, 3-sample majority vote per bit, registered byte/valid/framing outputs.
module rs232_rxd
    import rs232_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clock16x,
    input  logic                 Reset,
    input  logic                 Rxd,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 DataValid,
    output logic                 FramingError,
    output logic                 RxBusy
);

    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    rxState_t             state_r, stateNext_s;
    logic [3:0]           tickCnt_r, tickNext_s;
    logic [BC_W-1:0]      bitCnt_r, bitNext_s;
    logic [DATA_BITS-1:0] shreg_r, shregNext_s, dataNext_s;
    logic                 s7_r, s7Next_s, s8_r, s8Next_s;
    logic                 dvNext_s, feNext_s;
    logic                 rxs_s, sampleBit_s, atDecide_s, atLast_s;

    rs232_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .Clock16x (Clock16x),
        .Reset    (Reset),
        .Din      (Rxd),
        .Dout     (rxs_s)
    );

    assign atDecide_s  = (tickCnt_r == 4'(SAMPLE_DECIDE));
    assign atLast_s    = (tickCnt_r == 4'(TICK_LAST));
    assign sampleBit_s = majority3(s7_r, s8_r, rxs_s);

    // Next-state and datapath decode; tick counter wraps 15->0 through 4-bit overflow
    always_comb begin
        stateNext_s = state_r;
        tickNext_s  = tickCnt_r + 4'd1;
        bitNext_s   = bitCnt_r;
        shregNext_s = shreg_r;
        dataNext_s  = DataOut;
        dvNext_s    = 1'b0;
        feNext_s    = 1'b0;
        if (tickCnt_r == 4'(SAMPLE_FIRST)) begin
            s7Next_s = rxs_s;
        end else begin
            s7Next_s = s7_r;
        end
        if (tickCnt_r == 4'(SAMPLE_FIRST + 1)) begin
            s8Next_s = rxs_s;
        end else begin
            s8Next_s = s8_r;
        end
        case (state_r)
            stIdle: begin
                tickNext_s = 4'd0;
                if (!rxs_s) begin
                    stateNext_s = stStart;
                end else begin
                    stateNext_s = stIdle;
                end
            end
            stStart: begin
                if (atDecide_s && sampleBit_s) begin
                    stateNext_s = stIdle;
                    tickNext_s  = 4'd0;
                end else if (atLast_s) begin
                    stateNext_s = stData;
                    bitNext_s   = '0;
                end else begin
                    stateNext_s = stStart;
                end
            end
            stData: begin
                if (atDecide_s) begin
                    shregNext_s = {sampleBit_s, shreg_r[DATA_BITS-1:1]};
                end else begin
                    shregNext_s = shreg_r;
                end
                if (atLast_s && (bitCnt_r == BC_W'(DATA_BITS - 1))) begin
                    stateNext_s = stStop;
                end else if (atLast_s) begin
                    bitNext_s = bitCnt_r + BC_W'(1);
                end else begin
                    bitNext_s = bitCnt_r;
                end
            end
            stStop: begin
                // Leave at mid-stop so a back-to-back start edge is not missed
                if (atDecide_s && sampleBit_s) begin
                    dataNext_s  = shreg_r;
                    dvNext_s    = 1'b1;
                    stateNext_s = stIdle;
                    tickNext_s  = 4'd0;
                end else if (atDecide_s) begin
                    feNext_s    = 1'b1;
                    stateNext_s = stWait;
                    tickNext_s  = 4'd0;
                end else begin
                    stateNext_s = stStop;
                end
            end
            stWait: begin
                tickNext_s = 4'd0;
                if (rxs_s) begin
                    stateNext_s = stIdle;
                end else begin
                    stateNext_s = stWait;
                end
            end
            default: begin
                stateNext_s = stIdle;
                tickNext_s  = 4'd0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge Clock16x or posedge Reset) begin
        if (Reset) begin
            state_r      <= stIdle;
            tickCnt_r    <= 4'd0;
            bitCnt_r     <= '0;
            shreg_r      <= '0;
            s7_r         <= 1'b1;
            s8_r         <= 1'b1;
            DataOut      <= '0;
            DataValid    <= 1'b0;
            FramingError <= 1'b0;
            RxBusy       <= 1'b0;
        end else begin
            state_r      <= stateNext_s;
            tickCnt_r    <= tickNext_s;
            bitCnt_r     <= bitNext_s;
            shreg_r      <= shregNext_s;
            s7_r         <= s7Next_s;
            s8_r         <= s8Next_s;
            DataOut      <= dataNext_s;
            DataValid    <= dvNext_s;
            FramingError <= feNext_s;
            RxBusy       <= (stateNext_s != stIdle);
        end
    end

endmodule

// File: tb/tb_rs232_rxd.sv
// Self-checking bench for rs232_rxd: serial frame driver plus a scoreboard of expected received bytes.
module tb_rs232_rxd;

    logic       Clock16x = 1'b0;
    logic       Reset    = 1'b1;
    logic       Rxd      = 1'b1;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       FramingError;
    logic       RxBusy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dvCount = 0;
    int feCount = 0;
    int lastDvCyc = 0;
    int frameStartCyc = 0;
    logic prevDv = 1'b0;
    logic prevFe = 1'b0;
    logic [7:0] expQ[$];

    rs232_rxd #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .Clock16x     (Clock16x),
        .Reset        (Reset),
        .Rxd          (Rxd),
        .DataOut      (DataOut),
        .DataValid    (DataValid),
        .FramingError (FramingError),
        .RxBusy       (RxBusy)
    );

    always #5 Clock16x = ~Clock16x;

    always @(posedge Clock16x) cyc <= cyc + 1;

    // Scoreboard monitor: sampled on the falling edge, away from the active edge
    always @(negedge Clock16x) begin
        if (!Reset) begin
            if (DataValid) begin
                dvCount++;
                lastDvCyc = cyc;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected_valid: got DataOut=%02h, expected no pulse", DataOut);
                end else begin
                    logic [7:0] exp;
                    exp = expQ.pop_front();
                    if (DataOut !== exp) begin
                        errors++;
                        $display("FAIL scoreboard_byte: got %02h, expected %02h", DataOut, exp);
                    end
                end
                checks++;
                if (FramingError !== 1'b0 || prevDv !== 1'b0) begin
                    errors++;
                    $display("FAIL pulse_exclusive: FramingError=%b prevValid=%b, expected 0 0", FramingError, prevDv);
                end
            end
            if (FramingError) begin
                feCount++;
                checks++;
                if (prevFe !== 1'b0) begin
                    errors++;
                    $display("FAIL fe_single_cycle: previous FramingError=%b, expected 0", prevFe);
                end
            end
        end
        prevDv = DataValid;
        prevFe = FramingError;
    end

    task automatic holdLine(input logic v, input int n);
        Rxd = v;
        repeat (n) @(posedge Clock16x);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int glitchBit);
        logic b;
        if (stopBit) expQ.push_back(d);
        frameStartCyc = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) b = 1'b0;
            else if (i == 9) b = stopBit;
            else b = d[i-1];
            if (i == glitchBit) begin
                holdLine(b, 8);
                holdLine(~b, 1);
                holdLine(b, 7);
            end else begin
                holdLine(b, 16);
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (DataOut !== 8'h00 || DataValid !== 1'b0 || FramingError !== 1'b0 || RxBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got out=%02h dv=%b fe=%b busy=%b, expected 00 0 0 0",
                     DataOut, DataValid, FramingError, RxBusy);
        end
        repeat (3) @(posedge Clock16x);
        #1;
        Reset = 1'b0;
        holdLine(1'b1, 10);
        checks++;
        if (RxBusy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b, expected 0", RxBusy);
        end
    endtask

    task automatic test_single_frame;
        int dv0, fe0;
        dv0 = dvCount;
        fe0 = feCount;
        sendFrame(8'hA5, 1'b1, -1);
        holdLine(1'b1, 20);
        checks++;
        if (dvCount - dv0 != 1 || feCount != fe0 || expQ.size() != 0) begin
            errors++;
            $display("FAIL t1_counts: got valid=%0d fe=%0d pending=%0d, expected 1 0 0",
                     dvCount - dv0, feCount - fe0, expQ.size());
        end
        checks++;
        if (lastDvCyc - frameStartCyc != 157) begin
            errors++;
            $display("FAIL t1_latency: got edge %0d, expected edge 156", lastDvCyc - frameStartCyc - 1);
        end
        checks++;
        if (DataOut !== 8'hA5) begin
            errors++;
            $display("FAIL t1_hold: got %02h, expected a5", DataOut);
        end
    endtask

    task automatic test_back_to_back;
        int dv0, fe0;
        dv0 = dvCount;
        fe0 = feCount;
        sendFrame(8'h00, 1'b1, -1);
        sendFrame(8'hFF, 1'b1, -1);
        sendFrame(8'h55, 1'b1, -1);
        holdLine(1'b1, 20);
        checks++;
        if (dvCount - dv0 != 3 || feCount != fe0 || expQ.size() != 0) begin
            errors++;
            $display("FAIL t2_counts: got valid=%0d fe=%0d pending=%0d, expected 3 0 0",
                     dvCount - dv0, feCount - fe0, expQ.size());
        end
        checks++;
        if (DataOut !== 8'h55) begin
            errors++;
            $display("FAIL t2_last: got %02h, expected 55", DataOut);
        end
    endtask

    task automatic test_glitch_reject;
        int dv0, fe0;
        dv0 = dvCount;
        fe0 = feCount;
        holdLine(1'b0, 5);
        checks++;
        if (RxBusy !== 1'b1) begin
            errors++;
            $display("FAIL t3_busy_rise: got %b, expected 1", RxBusy);
        end
        holdLine(1'b1, 25);
        checks++;
        if (RxBusy !== 1'b0 || dvCount != dv0 || feCount != fe0) begin
            errors++;
            $display("FAIL t3_reject: got busy=%b valid=%0d fe=%0d, expected 0 0 0",
                     RxBusy, dvCount - dv0, feCount - fe0);
        end
    endtask

    task automatic test_framing_error;
        int dv0, fe0;
        dv0 = dvCount;
        fe0 = feCount;
        sendFrame(8'h3C, 1'b0, -1);
        holdLine(1'b0, 40);
        checks++;
        if (feCount - fe0 != 1 || dvCount != dv0) begin
            errors++;
            $display("FAIL t4_flag: got fe=%0d valid=%0d, expected 1 0", feCount - fe0, dvCount - dv0);
        end
        checks++;
        if (DataOut !== 8'h55 || RxBusy !== 1'b1) begin
            errors++;
            $display("FAIL t4_wait: got out=%02h busy=%b, expected 55 1", DataOut, RxBusy);
        end
        holdLine(1'b1, 10);
        checks++;
        if (RxBusy !== 1'b0 || feCount - fe0 != 1) begin
            errors++;
            $display("FAIL t4_release: got busy=%b fe=%0d, expected 0 1", RxBusy, feCount - fe0);
        end
    endtask

    task automatic test_majority;
        sendFrame(8'h81, 1'b1, 4);
        holdLine(1'b1, 20);
        checks++;
        if (DataOut !== 8'h81 || expQ.size() != 0) begin
            errors++;
            $display("FAIL t5_majority: got %02h pending=%0d, expected 81 0", DataOut, expQ.size());
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        int dv0;
        d = 8'hC3;
        dv0 = dvCount;
        holdLine(1'b0, 16);
        for (int i = 0; i < 5; i++) holdLine(d[i], 16);
        holdLine(d[5], 4);
        Reset = 1'b1;
        #1;
        checks++;
        if (DataOut !== 8'h00 || DataValid !== 1'b0 || FramingError !== 1'b0 || RxBusy !== 1'b0) begin
            errors++;
            $display("FAIL t6_reset: got out=%02h dv=%b fe=%b busy=%b, expected 00 0 0 0",
                     DataOut, DataValid, FramingError, RxBusy);
        end
        Rxd = 1'b1;
        repeat (3) @(posedge Clock16x);
        #1;
        Reset = 1'b0;
        holdLine(1'b1, 5);
        sendFrame(8'h5A, 1'b1, -1);
        holdLine(1'b1, 20);
        checks++;
        if (DataOut !== 8'h5A || dvCount - dv0 != 1 || expQ.size() != 0) begin
            errors++;
            $display("FAIL t6_recover: got %02h valid=%0d pending=%0d, expected 5a 1 0",
                     DataOut, dvCount - dv0, expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch_reject();
        test_framing_error();
        test_majority();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
